// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device.
// The host inhibits the bus, requests to send, and then shifts the byte out
// on device-generated clock falls. It checks for the device ACK and recovers
// from timeouts. Line drive uses active-high pull-low enables.
`timescale 1ns / 1ps

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INH_W  = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned FILT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

    // First inhibit cycle index that also drives the start bit, and the index before it.
    localparam int unsigned SETUP_START = (INHIBIT_CYCLES > 10) ? INHIBIT_CYCLES - 10 : 0;
    localparam logic [INH_W-1:0] SETUP_PREV = INH_W'((SETUP_START > 0) ? SETUP_START - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    state_e              state_q;
    logic                clk_s1_q, clk_s2_q;
    logic                data_s1_q, data_s2_q;
    logic                filt_clk_q, filt_prev_q;
    logic [FILT_W-1:0]   filt_cnt_q;
    logic [INH_W-1:0]    inh_cnt_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic [7:0]          shreg_q;
    logic                parity_q;
    logic [3:0]          bitcnt_q;
    logic                err_flag_q;
    logic                fall;
    logic                timeout_hit;

    assign fall        = filt_prev_q & ~filt_clk_q;
    assign timeout_hit = (to_cnt_q == TO_LAST) && !fall;

    // Two-flop synchronisers; idle line level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data_in;
            data_s2_q <= data_s1_q;
        end
    end

    // Glitch filter: a new clock level is accepted after FILTER_CYCLES equal samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_prev_q <= filt_clk_q;
            if (clk_s2_q == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_clk_q <= clk_s2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // Transmit sequencer with registered line enables and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            bitcnt_q    <= '0;
            err_flag_q  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx_valid && tx_ready) begin
                        shreg_q     <= tx_data;
                        parity_q    <= ~^tx_data;
                        tx_ready    <= 1'b0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= (SETUP_START == 0);
                        inh_cnt_q   <= '0;
                        err_flag_q  <= 1'b0;
                        state_q     <= StInhibit;
                    end
                end
                StInhibit: begin
                    // Device clock activity here is ignored: the host owns the bus.
                    if (inh_cnt_q == INH_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        to_cnt_q    <= '0;
                        state_q     <= StReq;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                        if (inh_cnt_q >= SETUP_PREV) begin
                            ps2_data_oe <= 1'b1;
                        end
                    end
                end
                StReq, StData, StParity, StStop, StWaitIdle: begin
                    if (timeout_hit) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        // A missing ACK has already been reported for this byte.
                        tx_err      <= !err_flag_q;
                        tx_ready    <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        to_cnt_q <= fall ? '0 : to_cnt_q + 1'b1;
                        case (state_q)
                            StReq: begin
                                if (fall) begin
                                    ps2_data_oe <= ~shreg_q[0];
                                    bitcnt_q    <= 4'd1;
                                    state_q     <= StData;
                                end
                            end
                            StData: begin
                                if (fall) begin
                                    if (bitcnt_q == 4'd8) begin
                                        ps2_data_oe <= ~parity_q;
                                        state_q     <= StParity;
                                    end else begin
                                        ps2_data_oe <= ~shreg_q[bitcnt_q[2:0]];
                                        bitcnt_q    <= bitcnt_q + 1'b1;
                                    end
                                end
                            end
                            StParity: begin
                                if (fall) begin
                                    ps2_data_oe <= 1'b0;
                                    state_q     <= StStop;
                                end
                            end
                            StStop: begin
                                if (fall) begin
                                    if (data_s2_q) begin
                                        tx_err     <= 1'b1;
                                        err_flag_q <= 1'b1;
                                    end
                                    state_q <= StWaitIdle;
                                end
                            end
                            StWaitIdle: begin
                                if (filt_clk_q && data_s2_q) begin
                                    tx_done  <= !err_flag_q;
                                    tx_ready <= 1'b1;
                                    state_q  <= StIdle;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- It is the transmit counterpart of the PS/2 keyboard receive path at the top level.
- It drives the open-drain PS/2 clock and data lines through active-high pull-low enables; the top level makes the tristate (line = 0 when enable, else Z).
- The synchronised line values are fed back to this block.

Parameters:
- INHIBIT_CYCLES, default 12000: cycles the host holds PS/2 clock low before the request (120 us at 100 MHz).
- TIMEOUT_CYCLES, default 2000000: maximum cycles allowed between device clock falling edges, and from request to first edge (20 ms).
- FILTER_CYCLES, default 4: consecutive identical synchronised samples needed to accept a PS/2 clock level change.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset (0 = reset)
- tx_data  in  8  command byte
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  block idle, can accept a byte
- tx_done  out  1  one-cycle pulse: byte sent and acknowledged by device
- tx_err  out  1  one-cycle pulse: no ACK or timeout
- ps2_clk_in  in  1  raw PS/2 clock line level
- ps2_data_in  in  1  raw PS/2 data line level
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low

Behaviour:
- Input conditioning:
  - Both line inputs pass through a 2-flop synchroniser.
  - The clock then passes a FILTER_CYCLES glitch filter.
  - fall = one-cycle pulse when the filtered clock goes 1->0.
- Reset (reset=0, asynchronous):
  - state = IDLE; tx_ready=1; tx_done=0; tx_err=0; ps2_clk_oe=0; ps2_data_oe=0.
  - Counters and shift register cleared; filtered clock = 1.
  - Reset mid-frame releases both lines immediately.
- Accept:
  - In IDLE, tx_valid && tx_ready latches tx_data and the odd parity bit, p = ~^tx_data.
  - Next cycle: tx_ready=0, state = INHIBIT.
  - tx_valid outside IDLE is ignored; no queueing.
- INHIBIT:
  - clk_oe=1 for INHIBIT_CYCLES cycles.
  - data_oe is also asserted for the final 10 of those cycles (start bit 0 set up).
  - Then go to REQ.
- REQ:
  - clk_oe=0, data_oe=1. Wait for fall.
  - On fall: drive data bit 0 (data_oe = ~bit), go to DATA with bitcnt=1.
- DATA:
  - Each fall with bitcnt 1..7 drives bit[bitcnt] and increments bitcnt.
  - The fall at bitcnt=8 drives parity, go to PARITY.
  - Bits go out LSB first; data changes only in the cycle after fall.
- PARITY: on fall, data_oe=0 (stop bit = released line), go to STOP.
- STOP: on fall, sample synchronised data:
  - 0 -> device ACK, go to WAIT_IDLE.
  - 1 -> tx_err pulse, go to WAIT_IDLE with error flag set.
- WAIT_IDLE:
  - Wait until filtered clock=1 and synchronised data=1.
  - Then pulse tx_done (if no error), state = IDLE, tx_ready=1 in the same cycle.
- Timeout:
  - A counter runs in REQ through WAIT_IDLE and clears on every fall.
  - On reaching TIMEOUT_CYCLES: both oe=0, tx_err pulse, state = IDLE, tx_ready=1.
  - tx_done and tx_err are never asserted together. Exactly one of them pulses per accepted byte.
- Contention:
  - A device frame in progress at accept time is aborted by INHIBIT; that is standard PS/2 host priority.
  - Falls during INHIBIT are ignored.
- Latency: accept -> first clk_oe cycle = 1 cycle. Minimum frame ≈ INHIBIT_CYCLES + 11 device clocks.

Test Plan:
- Reset held low mid-DATA -> both oe=0 and tx_ready=1 within 0 cycles (async). After release the block is idle and accepts a new byte.
- Send 0xED, device model clocks at 12.5 kHz, ACKs on 11th fall -> bits on data line (line level) 0,1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse; clk_oe low for exactly 12000 cycles.
- Send 0x01 -> parity 0; send 0xFF -> parity 1; send 0x00 -> parity 1. All are checked at the 9th fall by the device model.
- Device model never pulls data low at 11th fall -> tx_err=1 for one cycle, no tx_done, lines released, tx_ready=1.
- Device model stops clocking after 4 falls -> tx_err exactly TIMEOUT_CYCLES after the 4th fall; both oe=0.
- 2-cycle glitch low on ps2_clk_in during DATA -> no fall, bit index unchanged. tx_valid pulsed while busy -> ignored; only the first byte is transmitted.
